// File: rtl/nx_stream_packer_if.sv
// Ctrl/mesh outbound message inputs plus the packed 64-bit host-facing stream.
// master = packer side (drives readies and the outbound beat); slave = core/host side.
interface nx_stream_packer_if #(
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int AXI4_ID_WIDTH   = 1
);
  localparam int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8;

  logic [30:0]                  ctrl_data;
  logic                         ctrl_valid;
  logic                         ctrl_ready;
  logic [30:0]                  mesh_data;
  logic                         mesh_valid;
  logic                         mesh_ready;
  logic [AXI4_DATA_WIDTH-1:0]   outbound_tdata;
  logic [AXI4_STRB_WIDTH-1:0]   outbound_tkeep;
  logic [AXI4_STRB_WIDTH-1:0]   outbound_tstrb;
  logic [AXI4_ID_WIDTH-1:0]     outbound_tid;
  logic                         outbound_tlast;
  logic                         outbound_tvalid;
  logic                         outbound_tready;
  logic                         idle;

  modport master (
    input  ctrl_data, ctrl_valid, mesh_data, mesh_valid, outbound_tready,
    output ctrl_ready, mesh_ready, outbound_tdata, outbound_tkeep, outbound_tstrb,
           outbound_tid, outbound_tlast, outbound_tvalid, idle
  );

  modport slave (
    output ctrl_data, ctrl_valid, mesh_data, mesh_valid, outbound_tready,
    input  ctrl_ready, mesh_ready, outbound_tdata, outbound_tkeep, outbound_tstrb,
           outbound_tid, outbound_tlast, outbound_tvalid, idle
  );
endinterface

// File: rtl/nx_stream_packer.sv
// Round-robin packs ctrl/mesh messages as {is_ctrl,payload} slots, two per beat; lone slot flushed after FLUSH_CYCLES.
// Pair -> tvalid one cycle after the second accept; while a beat stalls on tready both sources see ready low.
module nx_stream_packer #(
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8,
  parameter int AXI4_ID_WIDTH   = 1,
  parameter int FLUSH_CYCLES    = 8,
  parameter int MAX_BURST       = 16
) (
  input  logic               clk,
  input  logic               rstn,
  nx_stream_packer_if.master bus
);
  localparam int SLOT_W = AXI4_DATA_WIDTH / 2;
  localparam int TMR_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int CNT_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [AXI4_STRB_WIDTH-1:0] KEEP_FULL = '1;
  localparam logic [AXI4_STRB_WIDTH-1:0] KEEP_LOWER =
    {{(AXI4_STRB_WIDTH/2){1'b0}}, {(AXI4_STRB_WIDTH/2){1'b1}}};

  typedef struct packed {
    logic              is_ctrl;
    logic [SLOT_W-2:0] payload;
  } slot_t;

  typedef enum logic [1:0] {IDLE, HALF, SEND} state_t;

  state_t                     state;
  logic [TMR_W-1:0]           timer;
  logic [CNT_W-1:0]           beat_cnt;
  logic                       rr_ctrl;
  logic [AXI4_DATA_WIDTH-1:0] tdata_q;
  logic [AXI4_STRB_WIDTH-1:0] tkeep_q;
  logic                       tlast_q;
  logic                       tvalid_q;

  logic  grant_ctrl;
  logic  grant_mesh;
  logic  accept_allowed;
  logic  take;
  slot_t slot;

  // Only one source can be granted per cycle; rr_ctrl only matters when both are valid.
  always_comb begin
    grant_ctrl     = bus.ctrl_valid && (!bus.mesh_valid || rr_ctrl);
    grant_mesh     = bus.mesh_valid && !grant_ctrl;
    accept_allowed = (state != SEND) || bus.outbound_tready;
    take           = (grant_ctrl || grant_mesh) && accept_allowed;
    slot.is_ctrl   = grant_ctrl;
    slot.payload   = grant_ctrl ? bus.ctrl_data : bus.mesh_data;
  end

  assign bus.ctrl_ready      = grant_ctrl && accept_allowed;
  assign bus.mesh_ready      = grant_mesh && accept_allowed;
  assign bus.outbound_tdata  = tdata_q;
  assign bus.outbound_tkeep  = tkeep_q;
  assign bus.outbound_tstrb  = tkeep_q;
  assign bus.outbound_tid    = {AXI4_ID_WIDTH{1'b0}};
  assign bus.outbound_tlast  = tlast_q;
  assign bus.outbound_tvalid = tvalid_q;
  assign bus.idle            = (state == IDLE) && !bus.ctrl_valid && !bus.mesh_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      timer    <= '0;
      beat_cnt <= '0;
      rr_ctrl  <= 1'b1;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      if (take) begin
        rr_ctrl <= !grant_ctrl;
      end

      case (state)
        IDLE: begin
          if (take) begin
            tdata_q[SLOT_W-1:0] <= slot;
            timer               <= '0;
            state               <= HALF;
          end
        end

        HALF: begin
          if (take) begin
            tdata_q[AXI4_DATA_WIDTH-1:SLOT_W] <= slot;
            tkeep_q  <= KEEP_FULL;
            tlast_q  <= (beat_cnt == CNT_LAST);
            tvalid_q <= 1'b1;
            state    <= SEND;
          end else if (timer == TMR_LAST) begin
            // Flushed half beats always close the packet.
            tdata_q[AXI4_DATA_WIDTH-1:SLOT_W] <= '0;
            tkeep_q  <= KEEP_LOWER;
            tlast_q  <= 1'b1;
            tvalid_q <= 1'b1;
            state    <= SEND;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        SEND: begin
          if (bus.outbound_tready) begin
            beat_cnt <= tlast_q ? '0 : beat_cnt + 1'b1;
            tvalid_q <= 1'b0;
            if (take) begin
              tdata_q[SLOT_W-1:0] <= slot;
              timer               <= '0;
              state               <= HALF;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state    <= IDLE;
          tvalid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nx_stream_packer.sv
// Directed + randomized bench for nx_stream_packer against a slot-queue reference model.
module tb_nx_stream_packer;
  localparam int FLUSH = 8;
  localparam int MAXB  = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nx_stream_packer_if #(.AXI4_DATA_WIDTH(64), .AXI4_ID_WIDTH(1)) bus ();

  nx_stream_packer #(
    .AXI4_DATA_WIDTH(64),
    .AXI4_ID_WIDTH  (1),
    .FLUSH_CYCLES   (FLUSH),
    .MAX_BURST      (MAXB)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: slots held by the packer, the beat on offer, packet position.
  int          cyc = 0;
  bit          rr_ctrl;
  logic [31:0] held[$];
  int          held_cyc;
  bit          beat_pend;
  logic [63:0] beat_dat;
  logic [7:0]  beat_keep;
  bit          beat_last;
  int          pkt_cnt;

  bit last_cr, last_mr;
  bit grant_q[$];
  bit obs_last_q[$];
  logic [63:0] saved_dat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rr_ctrl   = 1'b1;
    held.delete();
    beat_pend = 1'b0;
    pkt_cnt   = 0;
  endtask

  task automatic set_in(input bit cv, input logic [30:0] cd, input bit mv, input logic [30:0] md);
    bus.ctrl_valid = cv;
    bus.ctrl_data  = cd;
    bus.mesh_valid = mv;
    bus.mesh_data  = md;
  endtask

  // One clock: compare DUT to the model at negedge, advance the model across the posedge.
  task automatic cycle();
    bit allow, gc, gm, take, hs;
    logic [31:0] s;
    @(negedge clk);
    cyc++;
    allow = !beat_pend || bus.outbound_tready;
    gc    = bus.ctrl_valid && (!bus.mesh_valid || rr_ctrl);
    gm    = bus.mesh_valid && !gc;
    take  = (gc || gm) && allow;
    check("ctrl_ready", bus.ctrl_ready, gc && allow);
    check("mesh_ready", bus.mesh_ready, gm && allow);
    check("idle", bus.idle, !beat_pend && held.size() == 0 && !bus.ctrl_valid && !bus.mesh_valid);
    check("tvalid", bus.outbound_tvalid, beat_pend);
    check("tid", bus.outbound_tid, 0);
    if (beat_pend) begin
      check("tdata", bus.outbound_tdata, beat_dat);
      check("tkeep", bus.outbound_tkeep, beat_keep);
      check("tstrb", bus.outbound_tstrb, beat_keep);
      check("tlast", bus.outbound_tlast, beat_last);
    end
    last_cr = bus.ctrl_ready;
    last_mr = bus.mesh_ready;
    if (bus.ctrl_ready) grant_q.push_back(1'b1);
    if (bus.mesh_ready) grant_q.push_back(1'b0);
    if (bus.outbound_tvalid && bus.outbound_tready) obs_last_q.push_back(bus.outbound_tlast);

    hs = beat_pend && bus.outbound_tready;
    if (hs) begin
      pkt_cnt   = beat_last ? 0 : pkt_cnt + 1;
      beat_pend = 1'b0;
    end
    if (take) begin
      s = gc ? {1'b1, bus.ctrl_data} : {1'b0, bus.mesh_data};
      rr_ctrl = !gc;
      held.push_back(s);
      if (held.size() == 1) held_cyc = cyc;
      if (held.size() == 2) begin
        beat_dat  = {held[1], held[0]};
        beat_keep = 8'hFF;
        beat_last = (pkt_cnt == MAXB - 1);
        beat_pend = 1'b1;
        held.delete();
      end
    end else if (held.size() == 1 && cyc - held_cyc == FLUSH) begin
      beat_dat  = {32'h0, held[0]};
      beat_keep = 8'h0F;
      beat_last = 1'b1;
      beat_pend = 1'b1;
      held.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, '0, 0, '0);
    rstn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic stream_mesh(input int n);
    int sent = 0;
    int budget = 0;
    while (sent < n && budget < 8 * n + 20) begin
      set_in(0, '0, 1, 31'(sent + 'h100));
      cycle();
      if (last_mr) sent++;
      budget++;
    end
    set_in(0, '0, 0, '0);
    check("stream_sent", sent, n);
  endtask

  initial begin
    set_in(0, '0, 0, '0);
    bus.outbound_tready = 1'b1;
    model_reset();
    #1;
    check("rst_tvalid", bus.outbound_tvalid, 0);
    check("rst_tdata", bus.outbound_tdata, 0);
    check("rst_tkeep", bus.outbound_tkeep, 0);
    check("rst_tstrb", bus.outbound_tstrb, 0);
    check("rst_tlast", bus.outbound_tlast, 0);
    check("rst_idle", bus.idle, 1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Lone ctrl message flushes after FLUSH cycles.
    set_in(1, 31'h12345678, 0, '0);
    cycle();
    set_in(0, '0, 0, '0);
    repeat (FLUSH) cycle();
    check("t1_tvalid", bus.outbound_tvalid, 1);
    check("t1_lower", bus.outbound_tdata[31:0], 32'h92345678);
    check("t1_tkeep", bus.outbound_tkeep, 8'h0F);
    check("t1_tlast", bus.outbound_tlast, 1);
    cycle();

    // Both sources continuously valid: ctrl first, then alternation.
    do_reset();
    grant_q.delete();
    set_in(1, 31'h1, 1, 31'h2);
    cycle();
    cycle();
    check("t2_tvalid", bus.outbound_tvalid, 1);
    check("t2_tdata", bus.outbound_tdata, 64'h00000002_80000001);
    check("t2_tkeep", bus.outbound_tkeep, 8'hFF);
    repeat (4) cycle();
    check("t2_grants", grant_q.size(), 6);
    for (int i = 0; i < 6 && i < grant_q.size(); i++)
      check($sformatf("t2_grant%0d", i), grant_q[i], (i % 2) == 0);
    set_in(0, '0, 0, '0);
    repeat (FLUSH + 3) cycle();

    // 32 mesh messages -> 16 full beats, tlast only on the 16th.
    do_reset();
    obs_last_q.delete();
    stream_mesh(32);
    repeat (FLUSH + 3) cycle();
    check("t3_beats", obs_last_q.size(), 16);
    for (int i = 0; i < 16 && i < obs_last_q.size(); i++)
      check($sformatf("t3_tlast%0d", i), obs_last_q[i], i == 15);
    stream_mesh(2);
    repeat (3) cycle();
    check("t3_beats17", obs_last_q.size(), 17);
    if (obs_last_q.size() > 16) check("t3_tlast17", obs_last_q[16], 0);

    // Backpressure: beat stable, readies low for 5 cycles.
    bus.outbound_tready = 1'b0;
    set_in(1, 31'h0A, 0, '0);
    cycle();
    set_in(1, 31'h0B, 0, '0);
    cycle();
    check("t4_tvalid", bus.outbound_tvalid, 1);
    saved_dat = bus.outbound_tdata;
    set_in(1, 31'h0C, 1, 31'h0D);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_ctrl_ready", last_cr, 0);
      check("t4_mesh_ready", last_mr, 0);
      check("t4_tdata_stable", bus.outbound_tdata, saved_dat);
    end
    bus.outbound_tready = 1'b1;
    set_in(0, '0, 0, '0);
    cycle();
    repeat (FLUSH + 3) cycle();

    // Retire and capture in the same cycle: no IDLE bubble.
    set_in(1, 31'h55, 0, '0);
    cycle();
    set_in(0, '0, 1, 31'h66);
    cycle();
    set_in(1, 31'h77, 0, '0);
    cycle();
    set_in(0, '0, 0, '0);
    #1;
    check("t5_tvalid", bus.outbound_tvalid, 0);
    check("t5_not_idle", bus.idle, 0);
    repeat (FLUSH) cycle();
    check("t5_flush_valid", bus.outbound_tvalid, 1);
    check("t5_flush_dat", bus.outbound_tdata, 64'h00000000_80000077);
    cycle();

    // Reset during SEND drops outputs without a clock edge.
    bus.outbound_tready = 1'b0;
    set_in(1, 31'h21, 0, '0);
    cycle();
    set_in(1, 31'h22, 0, '0);
    cycle();
    set_in(0, '0, 0, '0);
    check("t6_pre_tvalid", bus.outbound_tvalid, 1);
    rstn = 1'b0;
    model_reset();
    #1;
    check("t6_async_tvalid", bus.outbound_tvalid, 0);
    check("t6_async_tdata", bus.outbound_tdata, 0);
    check("t6_async_tkeep", bus.outbound_tkeep, 0);
    check("t6_async_tlast", bus.outbound_tlast, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    bus.outbound_tready = 1'b1;

    // Reset while a slot is held in HALF; pointer left at mesh beforehand.
    set_in(1, 31'h31, 0, '0);
    cycle();
    set_in(1, 31'h7AAAAAAA, 0, '0);
    cycle();
    cycle();
    set_in(0, '0, 0, '0);
    check("t6_half_tvalid", bus.outbound_tvalid, 0);
    do_reset();
    set_in(1, 31'h11, 1, 31'h22);
    cycle();
    cycle();
    check("t6_new_tvalid", bus.outbound_tvalid, 1);
    check("t6_new_tdata", bus.outbound_tdata, 64'h00000022_80000011);
    check("t6_new_tlast", bus.outbound_tlast, 0);
    set_in(0, '0, 0, '0);
    cycle();

    // Randomized traffic at several load/backpressure mixes.
    for (int ph = 0; ph < 4; ph++) begin
      int pc, pm, pt;
      pc = (ph == 0) ? 50 : (ph == 1) ? 90 : (ph == 2) ? 20 : 70;
      pm = (ph == 0) ? 50 : (ph == 1) ? 90 : (ph == 2) ? 10 : 30;
      pt = (ph == 0) ? 100 : (ph == 1) ? 50 : (ph == 2) ? 80 : 30;
      for (int i = 0; i < 600; i++) begin
        set_in($urandom_range(99) < pc, 31'($urandom), $urandom_range(99) < pm, 31'($urandom));
        bus.outbound_tready = $urandom_range(99) < pt;
        cycle();
      end
    end
    set_in(0, '0, 0, '0);
    bus.outbound_tready = 1'b1;
    repeat (FLUSH + 4) cycle();
    check("drain_idle", bus.idle, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
